// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream_mux_arb slice.
//   MODE_SEL / MODE_RR : channel selection mode encodings
//   clog2_min1()       : ceil(log2(n)) clamped to at least 1, used to size
//                        channel-index fields so NCH=1 still gets a 1-bit index
package stream_mux_arb_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter for stream_mux_arb.
//   clk_i        clock
//   rst_i        synchronous active-high reset (pointer -> NCH-1, so ch0 wins first)
//   req_i        per-channel request vector
//   advance_i    transfer strobe; moves the pointer to the current grant
//   gnt_idx_o    granted channel index (combinational)
//   gnt_valid_o  at least one request is present
module rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2_min1(NCH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NCH-1:0]  req_i,
    input  logic            advance_i,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;

    // Scan from lowest to highest priority so the highest-priority hit,
    // ptr+1, is the one left standing.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            for (int i = 0; i < NCH; i++) begin
                if (i == ((int'(ptr_q) + k) % NCH) && req_i[i]) begin
                    gnt_idx_o   = SELW'(i);
                    gnt_valid_o = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = gnt_idx_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= SELW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// One channel is granted per cycle (explicit index or round-robin) and its
// word is captured in a single output register.
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   in_data_i    channel i at [i*WIDTH +: WIDTH]
//   in_valid_i   per-channel valid
//   in_ready_o   per-channel ready, at most one bit set
//   sel_i        channel index (MODE_SEL only)
//   out_data_o   registered data
//   out_valid_o  output register holds a word
//   out_ready_i  sink accepts the held word this cycle
//   out_ch_o     source channel of the held word
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SELW  = clog2_min1(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    input  logic [NCH-1:0]       in_valid_i,
    output logic [NCH-1:0]       in_ready_o,
    input  logic [SELW-1:0]      sel_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [SELW-1:0]      out_ch_o
);

    logic             load;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_valid;
    logic [WIDTH-1:0] gnt_data;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;

    // Register is free when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready_i;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic xfer;
            logic unused_sel;

            // Pointer only moves on a real transfer, never while stalled or in reset.
            assign xfer       = load && gnt_valid && !rst_i;
            assign unused_sel = ^sel_i;

            rr_arbiter #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_rr_arbiter (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .req_i       (in_valid_i),
                .advance_i   (xfer),
                .gnt_idx_o   (gnt_idx),
                .gnt_valid_o (gnt_valid)
            );
        end else if (NCH == 1) begin : g_single
            logic unused_sel;

            assign unused_sel = ^sel_i;
            assign gnt_idx    = '0;
            assign gnt_valid  = in_valid_i[0];
        end else begin : g_sel
            // An out-of-range index matches no channel and so yields no grant.
            always_comb begin
                gnt_idx   = sel_i;
                gnt_valid = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (int'(sel_i) == i) begin
                        gnt_valid = in_valid_i[i];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        in_ready_o = '0;
        gnt_data   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(gnt_idx) == i) begin
                gnt_data      = in_data_i[i*WIDTH +: WIDTH];
                in_ready_o[i] = load && gnt_valid && !rst_i;
            end
        end
    end

    // On load without a grant only valid drops; data and channel keep their last values.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;

endmodule
